// File: rtl/branch_predict_tournament_pkg.sv
// Shared encodings for the tournament branch predictor: 2-bit counter codes,
// choice-table codes, controller states and a small sizing helper.
package branch_predict_tournament_pkg;

    // Direction counter codes (local and global PHTs)
    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    // Choice counter codes; bit 1 set selects the global predictor
    localparam logic [1:0] CHC_STRONG_LOCAL  = 2'b00;
    localparam logic [1:0] CHC_WEAK_LOCAL    = 2'b01;
    localparam logic [1:0] CHC_WEAK_GLOBAL   = 2'b10;
    localparam logic [1:0] CHC_STRONG_GLOBAL = 2'b11;

    // Table-clearing phase followed by normal operation
    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/branch_predict_tournament_pipe_reg.sv
// bp_pipe_reg: one pipeline stage register for the predictor payload.
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over en),
//        en (load enable), d (next payload), q (registered payload).
module bp_pipe_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // Clear has priority over the load enable
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/branch_predict_tournament.sv
// Tournament branch direction predictor: per-PC local history (BHT -> local
// PHT), gshare global predictor (speculative GHR ^ PC -> global PHT) and a
// per-PC choice table. Predicts in F, consumed in D, trains in M.
// Ports:
//   clk, rst (async active-low)
//   flushD/stallD, flushE, flushM : pipeline stage controls
//   pcF, pcM                      : fetch PC and PC of the M instruction
//   branchD, branchM              : D / M instruction is a conditional branch
//   actual_takeM                  : resolved direction of the M branch
//   pred_takeD                    : predicted taken for the D instruction
//   correct                       : M prediction matched the resolved direction
//   init_done                     : tables cleared, predictor active
module branch_predict_tournament
    import branch_predict_tournament_pkg::*;
#(
    parameter int unsigned BHT_DEPTH  = 10,
    parameter int unsigned LHIST_W    = 6,
    parameter int unsigned GHR_W      = 8,
    parameter int unsigned CPHT_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flushD,
    input  logic        stallD,
    input  logic        flushE,
    input  logic        flushM,
    input  logic [31:0] pcF,
    input  logic [31:0] pcM,
    input  logic        branchD,
    input  logic        branchM,
    input  logic        actual_takeM,
    output logic        pred_takeD,
    output logic        correct,
    output logic        init_done
);

    localparam int unsigned MAXD   = max_u(max_u(BHT_DEPTH, LHIST_W), max_u(GHR_W, CPHT_DEPTH));
    localparam int unsigned PCM_HI = max_u(max_u(BHT_DEPTH, LHIST_W), CPHT_DEPTH) + 1;
    localparam int unsigned BHT_N  = 1 << BHT_DEPTH;
    localparam int unsigned LPHT_N = 1 << LHIST_W;
    localparam int unsigned GPHT_N = 1 << GHR_W;
    localparam int unsigned CPHT_N = 1 << CPHT_DEPTH;

    // Payload carried F -> D -> E -> M
    typedef struct packed {
        logic             pred;
        logic             lp;
        logic             gp;
        logic [GHR_W-1:0] gidx;
    } stage_t;

    localparam int unsigned STAGE_W = $bits(stage_t);

    // Saturating 2-bit counter step
    function automatic logic [1:0] sat_step(input logic [1:0] v, input logic up);
        logic [1:0] r;
        r = v;
        if (up) begin
            if (v != CTR_STRONG_T) r = v + 2'd1;
        end else begin
            if (v != CTR_STRONG_NT) r = v - 2'd1;
        end
        return r;
    endfunction

    // Prediction tables; cleared by the INIT sweep rather than by reset
    logic [LHIST_W-1:0] bht_q  [BHT_N];
    logic [1:0]         lpht_q [LPHT_N];
    logic [1:0]         gpht_q [GPHT_N];
    logic [1:0]         cpht_q [CPHT_N];

    bp_state_e         state_q, state_d;
    logic [MAXD-1:0]   cnt_q, cnt_d;
    logic [GHR_W-1:0]  spec_ghr_q, spec_ghr_d;
    logic [GHR_W-1:0]  ret_ghr_q, ret_ghr_d;
    logic              run;

    assign run       = (state_q == BP_RUN);
    assign init_done = run;

    // ---------------- init controller ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == BP_INIT) begin
            cnt_d = cnt_q + MAXD'(1);
            if (&cnt_q) begin
                state_d = BP_RUN;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BP_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- F-stage lookup ----------------
    logic [BHT_DEPTH-1:0]  bht_idx_f;
    logic [LHIST_W-1:0]    lidx_f;
    logic [GHR_W-1:0]      gidx_f;
    logic [CPHT_DEPTH-1:0] cidx_f;
    stage_t                f_s, d_s, e_s, m_s;

    assign bht_idx_f = pcF[BHT_DEPTH+1:2];
    assign lidx_f    = pcF[LHIST_W+1:2] ^ bht_q[bht_idx_f];
    assign gidx_f    = pcF[GHR_W+1:2] ^ spec_ghr_q;
    assign cidx_f    = pcF[CPHT_DEPTH+1:2];

    always_comb begin
        f_s      = '0;
        f_s.lp   = lpht_q[lidx_f][1];
        f_s.gp   = gpht_q[gidx_f][1];
        f_s.gidx = gidx_f;
        f_s.pred = cpht_q[cidx_f][1] ? f_s.gp : f_s.lp;
    end

    // ---------------- stage registers ----------------
    bp_pipe_reg #(.W(STAGE_W)) u_fd (
        .clk   (clk),
        .rst_n (rst),
        .clr   (flushD),
        .en    (~stallD),
        .d     (f_s),
        .q     (d_s)
    );

    bp_pipe_reg #(.W(STAGE_W)) u_de (
        .clk   (clk),
        .rst_n (rst),
        .clr   (flushE),
        .en    (1'b1),
        .d     (d_s),
        .q     (e_s)
    );

    bp_pipe_reg #(.W(STAGE_W)) u_em (
        .clk   (clk),
        .rst_n (rst),
        .clr   (flushM),
        .en    (1'b1),
        .d     (e_s),
        .q     (m_s)
    );

    assign pred_takeD = branchD & d_s.pred & run;
    assign correct    = ~run | (actual_takeM == (branchM & m_s.pred));

    // ---------------- M-stage training / INIT sweep ----------------
    logic [BHT_DEPTH-1:0]  bht_idx_m;
    logic [LHIST_W-1:0]    bht_old_m;
    logic [LHIST_W-1:0]    lidx_m;
    logic [CPHT_DEPTH-1:0] cidx_m;

    assign bht_idx_m = pcM[BHT_DEPTH+1:2];
    assign bht_old_m = bht_q[bht_idx_m];
    assign lidx_m    = pcM[LHIST_W+1:2] ^ bht_old_m;
    assign cidx_m    = pcM[CPHT_DEPTH+1:2];

    logic                  bht_we, lpht_we, gpht_we, cpht_we;
    logic [BHT_DEPTH-1:0]  bht_wa;
    logic [LHIST_W-1:0]    lpht_wa;
    logic [GHR_W-1:0]      gpht_wa;
    logic [CPHT_DEPTH-1:0] cpht_wa;
    logic [LHIST_W-1:0]    bht_wd;
    logic [1:0]            lpht_wd, gpht_wd, cpht_wd;

    always_comb begin
        bht_we  = 1'b0;
        lpht_we = 1'b0;
        gpht_we = 1'b0;
        cpht_we = 1'b0;
        bht_wa  = '0;
        lpht_wa = '0;
        gpht_wa = '0;
        cpht_wa = '0;
        bht_wd  = '0;
        lpht_wd = CTR_WEAK_T;
        gpht_wd = CTR_WEAK_T;
        cpht_wd = CHC_WEAK_LOCAL;
        if (!run) begin
            // Sweep: shallower tables stop once cnt passes their depth
            bht_we  = 32'(cnt_q) < BHT_N;
            lpht_we = 32'(cnt_q) < LPHT_N;
            gpht_we = 32'(cnt_q) < GPHT_N;
            cpht_we = 32'(cnt_q) < CPHT_N;
            bht_wa  = BHT_DEPTH'(cnt_q);
            lpht_wa = LHIST_W'(cnt_q);
            gpht_wa = GHR_W'(cnt_q);
            cpht_wa = CPHT_DEPTH'(cnt_q);
        end else if (branchM) begin
            bht_we  = 1'b1;
            bht_wa  = bht_idx_m;
            bht_wd  = {bht_old_m[LHIST_W-2:0], actual_takeM};
            lpht_we = 1'b1;
            lpht_wa = lidx_m;
            lpht_wd = sat_step(lpht_q[lidx_m], actual_takeM);
            // Global PHT trains the entry it predicted from, not a recomputed one
            gpht_we = 1'b1;
            gpht_wa = m_s.gidx;
            gpht_wd = sat_step(gpht_q[m_s.gidx], actual_takeM);
            // Chooser only learns when the two components disagreed
            cpht_we = (m_s.lp != m_s.gp);
            cpht_wa = cidx_m;
            cpht_wd = sat_step(cpht_q[cidx_m], m_s.gp == actual_takeM);
        end
    end

    always_ff @(posedge clk) begin
        if (bht_we)  bht_q[bht_wa]   <= bht_wd;
        if (lpht_we) lpht_q[lpht_wa] <= lpht_wd;
        if (gpht_we) gpht_q[gpht_wa] <= gpht_wd;
        if (cpht_we) cpht_q[cpht_wa] <= cpht_wd;
    end

    // ---------------- global history ----------------
    always_comb begin
        spec_ghr_d = spec_ghr_q;
        ret_ghr_d  = ret_ghr_q;
        if (run) begin
            if (branchM) begin
                ret_ghr_d = {ret_ghr_q[GHR_W-2:0], actual_takeM};
            end
            // Mispredict repair overrides a speculative shift from D
            if (branchM && !correct) begin
                spec_ghr_d = {ret_ghr_q[GHR_W-2:0], actual_takeM};
            end else if (branchD && !stallD && !flushD) begin
                spec_ghr_d = {spec_ghr_q[GHR_W-2:0], pred_takeD};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spec_ghr_q <= '0;
            ret_ghr_q  <= '0;
        end else begin
            spec_ghr_q <= spec_ghr_d;
            ret_ghr_q  <= ret_ghr_d;
        end
    end

    // PC bits outside every table index
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pcF[31:MAXD+2], pcF[1:0], pcM[31:PCM_HI+1], pcM[1:0]};

endmodule

// File: tb/tb_branch_predict_tournament.sv
// Directed bench for branch_predict_tournament: init sweep length, cold
// prediction, a TTTN loop trained through local history, mispredict repair
// of the speculative GHR, stall/flush handling and an asynchronous re-reset.
module tb_branch_predict_tournament;

    logic        clk;
    logic        rst;
    logic        flushD, stallD, flushE, flushM;
    logic [31:0] pcF, pcM;
    logic        branchD, branchM, actual_takeM;
    logic        pred_takeD, correct, init_done;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [31:0] PC_LOOP = 32'h0040_0010;
    localparam logic [31:0] PC_NT   = 32'h0040_00CC;
    localparam logic [31:0] PC_AUX  = 32'h0040_0100;
    localparam logic [31:0] PC_AUX2 = 32'h0040_0200;

    branch_predict_tournament dut (
        .clk          (clk),
        .rst          (rst),
        .flushD       (flushD),
        .stallD       (stallD),
        .flushE       (flushE),
        .flushM       (flushM),
        .pcF          (pcF),
        .pcM          (pcM),
        .branchD      (branchD),
        .branchM      (branchM),
        .actual_takeM (actual_takeM),
        .pred_takeD   (pred_takeD),
        .correct      (correct),
        .init_done    (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts rising edges until init_done; INIT must take exactly 1024 cycles
    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 2000) begin
            step();
            n++;
            if (n == 1 || n == 512 || n == 1023) begin
                #1;
                check_eq($sformatf("%s_done_%0d", tag, n), init_done, 0);
                check_eq($sformatf("%s_pred_%0d", tag, n), pred_takeD, 0);
                check_eq($sformatf("%s_corr_%0d", tag, n), correct, 1);
            end
        end
        check_eq($sformatf("%s_len", tag), n, 1024);
        branchD      = 1'b0;
        branchM      = 1'b0;
        actual_takeM = 1'b0;
    endtask

    // One branch flowing F, D, E, M with no overlap
    task automatic issue(input int k, input logic taken, input logic exp_pred, input logic exp_corr);
        pcF = PC_LOOP; branchD = 1'b0; branchM = 1'b0;
        step();
        branchD = 1'b1;
        #2 check_eq($sformatf("loop_pred_%0d", k), pred_takeD, exp_pred);
        step();
        branchD = 1'b0;
        step();
        branchM = 1'b1; pcM = PC_LOOP; actual_takeM = taken;
        #2 check_eq($sformatf("loop_corr_%0d", k), correct, exp_corr);
        step();
        branchM = 1'b0;
    endtask

    logic [7:0] ret_bits;

    initial begin
        rst = 1'b0;
        flushD = 1'b0; stallD = 1'b0; flushE = 1'b0; flushM = 1'b0;
        pcF = PC_LOOP; pcM = '0;
        branchD = 1'b1; branchM = 1'b1; actual_takeM = 1'b1;

        // In reset
        #3;
        check_eq("rst_done", init_done, 0);
        check_eq("rst_pred", pred_takeD, 0);
        check_eq("rst_corr", correct, 1);
        check_eq("rst_spec", dut.spec_ghr_q, 0);
        #19 rst = 1'b1;
        wait_init("init");

        // TTTN loop; k=0 is the cold prediction (weakly taken, weakly local)
        for (int k = 0; k < 24; k++) begin
            issue(k, (k % 4) != 3, ((k % 4) != 3) || (k < 8), !(k == 3 || k == 7));
        end

        // Build retGHR=0x2D with M-only branches whose carried prediction is 0
        flushM = 1'b1;
        step();
        ret_bits = 8'h2D;
        for (int i = 7; i >= 0; i--) begin
            branchM = 1'b1; pcM = PC_AUX; actual_takeM = ret_bits[i];
            flushD = (i == 0);
            #2 check_eq($sformatf("ghr_build_corr_%0d", i), correct, !ret_bits[i]);
            step();
        end
        branchM = 1'b0; flushD = 1'b0; branchD = 1'b1; pcF = PC_NT;
        #2;
        check_eq("rec_spec_a", dut.spec_ghr_q, 8'h2D);
        check_eq("rec_ret_a", dut.ret_ghr_q, 8'h2D);
        check_eq("rec_pred_a", pred_takeD, 0);
        step();
        branchD = 1'b1; branchM = 1'b1; actual_takeM = 1'b1; pcM = PC_AUX;
        #2;
        check_eq("rec_spec_b", dut.spec_ghr_q, 8'h5A);
        check_eq("rec_ret_b", dut.ret_ghr_q, 8'h2D);
        check_eq("rec_pred_b", pred_takeD, 0);
        check_eq("rec_corr_b", correct, 0);
        step();
        branchD = 1'b0; branchM = 1'b0;
        #2;
        check_eq("rec_spec_c", dut.spec_ghr_q, 8'h5B);
        check_eq("rec_ret_c", dut.ret_ghr_q, 8'h5B);
        flushM = 1'b0;
        step();

        // Stall holds a taken prediction while F looks at a not-taken PC
        pcF = PC_LOOP; stallD = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            stallD = 1'b1; branchD = 1'b1; pcF = PC_NT;
            #2 check_eq($sformatf("stall_pred_%0d", i), pred_takeD, 1);
            step();
        end
        check_eq("stall_spec", dut.spec_ghr_q, 8'h5B);
        stallD = 1'b0; branchD = 1'b0; flushE = 1'b1;
        step();
        flushE = 1'b0;
        step();
        branchM = 1'b1; actual_takeM = 1'b0; pcM = PC_AUX2;
        #2 check_eq("flushE_corr", correct, 1);
        step();
        branchM = 1'b0;

        // Asynchronous reset pulse mid-run
        #1 rst = 1'b0;
        #1;
        check_eq("rerst_done", init_done, 0);
        check_eq("rerst_spec", dut.spec_ghr_q, 0);
        check_eq("rerst_ret", dut.ret_ghr_q, 0);
        #3 rst = 1'b1;
        branchD = 1'b1; branchM = 1'b1; actual_takeM = 1'b1;
        wait_init("reinit");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
